// File: rtl/uart_rx_frame.sv
// ============================================================================
// Module   : uart_rx_frame
// Purpose  : UART receive framer. Synchronises the serial line, detects a
//            start bit, enables the external baud divider (bps_start) and
//            samples each bit on the rising edge of clk_bps (mid-bit).
//            Delivers the byte with a one-cycle strobe plus frame/parity
//            error flags.
// Options  : `define UART_RX_PARITY_EN to add an even-parity bit between the
//            data bits and the stop bit; otherwise parity_err is always 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frame #(
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       clk_bps,
  output logic       bps_start,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam int         ALIGN_SHR = 8 - DATA_BITS;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       rx_s1;
  logic       rx_s2;
  logic       rx_s3;
  logic       clk_bps_d;
  logic       tick;
  logic       fall_edge;

  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;

  logic       bps_start_nxt;
  logic       shift_en;
  logic       cnt_clr;
  logic       done;

`ifdef UART_RX_PARITY_EN
  logic       par_cap;
  logic       par_bad;
`endif

  // Two-flop synchroniser on rx, a third stage for edge detection, and a
  // delayed copy of clk_bps so only its rising edge produces a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1     <= 1'b0;
      rx_s2     <= 1'b0;
      rx_s3     <= 1'b0;
      clk_bps_d <= 1'b0;
    end else begin
      rx_s1     <= rx;
      rx_s2     <= rx_s1;
      rx_s3     <= rx_s2;
      clk_bps_d <= clk_bps;
    end
  end

  assign tick      = clk_bps & ~clk_bps_d;
  assign fall_edge = rx_s3 & ~rx_s2;

  // State register; reset parks in WAIT_IDLE so a low line cannot start a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-cycle control strobes for the datapath.
  always_comb begin
    state_nxt     = state;
    bps_start_nxt = bps_start;
    shift_en      = 1'b0;
    cnt_clr       = 1'b0;
    done          = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_cap       = 1'b0;
`endif
    case (state)
      WAIT_IDLE: begin
        bps_start_nxt = 1'b0;
        if (rx_s2) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (fall_edge) begin
          state_nxt     = START;
          bps_start_nxt = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s2) begin
            // Line back high at mid start bit: a glitch, not a frame.
            state_nxt     = IDLE;
            bps_start_nxt = 1'b0;
          end else begin
            state_nxt = DATA;
            cnt_clr   = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_cap   = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          done          = 1'b1;
          bps_start_nxt = 1'b0;
          // A low stop bit means a break or stuck line: wait for it to rise.
          state_nxt     = rx_s2 ? IDLE : WAIT_IDLE;
        end
      end
      default: begin
        state_nxt     = WAIT_IDLE;
        bps_start_nxt = 1'b0;
      end
    endcase
  end

  // Bit counter, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      bps_start  <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      bps_start <= bps_start_nxt;
      rx_valid  <= done;

      // Clearing the shift register keeps stale bits out of the parity sum
      // when DATA_BITS < 8.
      if (cnt_clr) begin
        bit_cnt   <= 3'd0;
        shift_reg <= 8'h00;
      end else if (shift_en) begin
        bit_cnt   <= bit_cnt + 3'd1;
        shift_reg <= {rx_s2, shift_reg[7:1]};
      end

      if (done) begin
        rx_data   <= shift_reg >> ALIGN_SHR;
        frame_err <= ~rx_s2;
`ifdef UART_RX_PARITY_EN
        parity_err <= par_bad;
`else
        parity_err <= 1'b0;
`endif
      end else begin
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: the received bit XOR all data bits must be 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad <= 1'b0;
    end else if (par_cap) begin
      par_bad <= rx_s2 ^ (^shift_reg);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// ============================================================================
// Module   : tb_uart_rx_frame
// Purpose  : Self-checking bench for uart_rx_frame. Models the baud divider
//            (434 clk per bit), drives serial frames and compares each
//            strobed byte against a queue of expected results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_frame;

  localparam int BIT_CLKS = 434;
  localparam int HALF     = 217;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       clk_bps;
  logic       bps_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t sb[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int strobe_cnt = 0;
  logic prev_valid = 1'b0;
  int unsigned div_cnt;

  always #10 clk = ~clk;

  uart_rx_frame #(.DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .clk_bps    (clk_bps),
    .bps_start  (bps_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  // Baud divider model: clk_bps pulses high for a few clocks at mid-bit.
  always_ff @(posedge clk) begin
    if (rst || !bps_start) begin
      div_cnt <= 0;
      clk_bps <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == BIT_CLKS - 1) ? 0 : div_cnt + 1;
      clk_bps <= (div_cnt >= HALF) && (div_cnt < HALF + 8);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard monitor: every strobe pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rx_valid) begin
        strobe_cnt++;
        check_eq("valid_width", prev_valid, 0);
        check_eq("bps_in_strobe", bps_start, 0);
        if (sb.size() == 0) begin
          check_eq("spurious_valid", rx_valid, 0);
        end else begin
          e = sb.pop_front();
          check_eq("rx_data", rx_data, e.data);
          check_eq("frame_err", frame_err, e.ferr);
          check_eq("parity_err", parity_err, e.perr);
        end
      end else if (prev_valid) begin
        check_eq("ferr_clear", frame_err, 0);
        check_eq("perr_clear", parity_err, 0);
      end
    end
    prev_valid = rx_valid;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame; rst_bit >= 0 pulses reset for one clk inside that bit slot.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit, input int rst_bit);
    logic bitv [12];
    int   n;
    bitv[0] = 1'b0;
    for (int i = 0; i < 8; i++) bitv[1 + i] = d[i];
    n = 9;
`ifdef UART_RX_PARITY_EN
    bitv[n] = pbit;
    n++;
`else
    if (pbit) n = 9;
`endif
    bitv[n] = stop;
    n++;
    for (int i = 0; i < n; i++) begin
      rx = bitv[i];
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (i == rst_bit && c == 100) begin
          rst = 1'b1;
          @(posedge clk);
          #1;
          rst = 1'b0;
          @(negedge clk);
          check_eq("rst_bps_start", bps_start, 0);
          check_eq("rst_rx_data", rx_data, 0);
          check_eq("rst_rx_valid", rx_valid, 0);
        end
        step(1);
      end
    end
  endtask

  // Push the expected result then send the frame.
  task automatic send_exp(input logic [7:0] d, input logic stop, input logic pbit);
    exp_t e;
    e.data = d;
    e.ferr = ~stop;
`ifdef UART_RX_PARITY_EN
    e.perr = pbit ^ (^d);
`else
    e.perr = 1'b0;
`endif
    sb.push_back(e);
    send_frame(d, stop, pbit, -1);
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && sb.size() != 0; c++) step(1);
    check_eq("sb_drain", sb.size(), 0);
  endtask

  initial begin
    int base;
    int bps_hi;
    rst = 1'b1;
    rx  = 1'b0;
    step(5);

    // Reset values, with the line held low across reset.
    @(negedge clk);
    check_eq("reset_bps_start", bps_start, 0);
    check_eq("reset_rx_data", rx_data, 0);
    check_eq("reset_rx_valid", rx_valid, 0);
    check_eq("reset_frame_err", frame_err, 0);
    check_eq("reset_parity_err", parity_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    bps_hi = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (bps_start) bps_hi++;
    end
    check_eq("low_line_no_start", bps_hi, 0);
    @(posedge clk);
    #1;
    rx = 1'b1;
    step(50);
    send_exp(8'h5A, 1'b1, ^8'h5A);
    wait_drain(BIT_CLKS);
    step(50);

    // Good byte.
    send_exp(8'hA5, 1'b1, ^8'hA5);
    wait_drain(BIT_CLKS);
    step(50);

    // Glitch: short low pulse must be rejected at the first tick.
    base = strobe_cnt;
    rx   = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step(1);
      if (c == 50) check_eq("glitch_bps_rise", bps_start, 1);
    end
    rx = 1'b1;
    for (int c = 0; c < 600 && bps_start; c++) step(1);
    check_eq("glitch_bps_fall", bps_start, 0);
    step(500);
    check_eq("glitch_no_strobe", strobe_cnt - base, 0);

    // Break: stop bit low and line held low for three bit times.
    base = strobe_cnt;
    send_exp(8'h3C, 1'b0, ^8'h3C);
    rx = 1'b0;
    step(2 * BIT_CLKS);
    check_eq("break_one_strobe", strobe_cnt - base, 1);
    wait_drain(10);
    rx = 1'b1;
    step(100);

    // Back-to-back frames, no idle gap.
    send_exp(8'h00, 1'b1, ^8'h00);
    send_exp(8'hFF, 1'b1, ^8'hFF);
    wait_drain(BIT_CLKS);
    step(50);

    // Parity handling.
`ifdef UART_RX_PARITY_EN
    send_exp(8'h07, 1'b1, 1'b1);
    wait_drain(BIT_CLKS);
    step(50);
    send_exp(8'h07, 1'b1, 1'b0);
    wait_drain(BIT_CLKS);
    step(50);
`else
    send_exp(8'h07, 1'b1, 1'b1);
    wait_drain(BIT_CLKS);
    step(50);
`endif

    // Reset during data bit 4; remaining bits stay high so no false start follows.
    base = strobe_cnt;
    send_frame(8'hF5, 1'b1, 1'b1, 5);
    step(BIT_CLKS);
    check_eq("midreset_no_strobe", strobe_cnt - base, 0);

    // Recovery frame after the mid-frame reset.
    send_exp(8'hC3, 1'b1, ^8'hC3);
    wait_drain(BIT_CLKS);
    step(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_frame.md
# uart_rx_frame

UART receive framer that turns the serial input line into parallel bytes. It sits directly upstream of the baud-rate clock divider (`clk_div`). When it detects a start bit it drives `bps_start` high, then samples the line on each rising edge of the divider's `clk_bps`, which falls mid-bit. It returns the byte with a one-cycle valid strobe and error flags to the logic-analyser control path.

## Interface
- `DATA_BITS`, 8, data bits per frame (legal range 5..8), sent LSB first.
- `clk`  in  1  system clock; every register is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line, idle high.
- `clk_bps`  in  1  level from the divider; its rising edge marks mid-bit.
- `bps_start`  out  1  divider enable; high for the whole frame.
- `rx_data`  out  8  received data; bits above `DATA_BITS-1` are 0; held until the next strobe.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` and the error flags are valid in this cycle.
- `frame_err`  out  1  stop bit sampled as 0; qualified by `rx_valid`.
- `parity_err`  out  1  parity mismatch; qualified by `rx_valid`; constant 0 without the macro.

## Operation
- **Synchronizer:** `rx` → `rx_s1` → `rx_s2`, two flops, both reset to 0. `rx_s3` is one more register on `rx_s2` for edge detection.
- **Tick:** `clk_bps_d` registers `clk_bps`. tick = `clk_bps & ~clk_bps_d`. The line is always sampled from `rx_s2` in the tick cycle.
- **States:** IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE. Reset enters WAIT_IDLE.
- **WAIT_IDLE → IDLE** when `rx_s2==1`. A line held low at or after reset therefore never triggers a start.
- **IDLE → START** on a falling edge (`rx_s3==1 && rx_s2==0`). `bps_start` goes high in the next cycle.
- **START:** at the first tick:
  - `rx_s2==1`: false start. Go to IDLE, drop `bps_start`, no strobe.
  - otherwise: go to DATA and clear the 3-bit bit counter.
- **DATA:** each tick shifts the sample into the MSB side of the shift register and increments the counter. After `DATA_BITS` ticks, go to PARITY (macro) or STOP.
- **PARITY:** one tick; sample compared with the expected parity.
- **STOP:** at its tick:
  - update `rx_data` (shift register right-aligned, upper bits zeroed), `frame_err`, `parity_err`;
  - drop `bps_start`;
  - if stop==1 go to IDLE, else go to WAIT_IDLE (break / low line), so no re-arm until the line is high.
- **Back-to-back frames:** a falling edge in the cycle right after the STOP tick is accepted from IDLE one cycle later. Start-edge loss is at most 2 clk, within the half-bit sampling margin.

## Timing
- **Reset values:** `bps_start`=0, `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `parity_err`=0, state WAIT_IDLE, counter 0.
- **Start latency:** `rx` falling edge → `bps_start` high after 3 clk (2 sync + 1 detect).
- **Frame end:** `rx_valid`, `rx_data`, `frame_err`, `parity_err` become valid in the cycle after the STOP tick. `bps_start` is 0 in that same cycle.
- **Strobe width:** `rx_valid` is high for exactly 1 clk. The error flags are cleared in the following cycle.
- **Reset mid-frame:** reset in any state drives every output to its reset value on the next clk edge, and no strobe is issued for the partial frame.
- **Missed tick:** ticks arriving while `bps_start`=0 are ignored. A `clk_bps` level still high after `bps_start` is deasserted creates no tick, because `clk_bps_d` tracks it.

## Configuration
- **`UART_RX_PARITY_EN` defined:** the PARITY state is compiled in; frame is start + `DATA_BITS` + even parity + stop. `parity_err` = sampled bit XOR (XOR-reduction of the data bits).
- **Not defined:** no PARITY state; frame is start + `DATA_BITS` + stop (8N1 at default); `parity_err` is tied to 0.

## Test plan
Bench: 50 MHz `clk`, `clk_div` instance with `uart_ctrl`=433 (115200 bps), `bps_start`/`clk_bps` connected to this block.
- **Good byte:** send 0xA5, 8N1 → exactly one `rx_valid` pulse, `rx_data`=0xA5, `frame_err`=0, `bps_start` low in the strobe cycle.
- **Glitch:** `rx` low for 100 clk, then high → `bps_start` rises then falls at the first tick; no `rx_valid`; state returns to IDLE.
- **Break:** send 0x3C with stop bit 0 and line held low 3 bit times → `rx_valid` with `rx_data`=0x3C, `frame_err`=1; no further strobe until the line is high and a new start arrives.
- **Back-to-back:** 0x00 then 0xFF with no idle gap → two strobes, data 0x00 then 0xFF, `frame_err`=0 both.
- **Parity (macro defined):**
  - 0x07 with parity bit 1 → `parity_err`=0.
  - 0x07 with parity bit 0 → `parity_err`=1.
  - Without the macro, 0x07 → `parity_err`=0.
- **Reset:**
  - `rst` for 1 clk during data bit 4 → `bps_start`=0 next clk; no strobe.
  - `rx` held low across reset release → `bps_start` stays 0 until `rx` goes high, then a new frame is received normally.
